// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: scanner state encoding, row/column keymap and idle code.
// Keypad consumers import this to decode hex_digit consistently.
package keypad_scanner_pkg;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_EMIT,
    ST_HOLD,
    ST_DEB_REL
  } state_e;

  localparam logic [3:0] IDLE_CODE = 4'hD;

  // Indexed by {row, col}; '*' reports as E and '#' as F.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all ones so an idle (pulled-up) keypad is seen during and after reset.
module keypad_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces press and release of one key,
// and emits its code with a single-cycle key_valid strobe per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] hex_digit,
  output logic       key_valid
);

  localparam int CNT_TOP = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  // Synced rows lag the column drive by two cycles; earlier samples belong to the previous column.
  localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(2);

  logic [3:0]       rows_s;
  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       hit_row;
  logic             any_low;
  logic             row_low;

  keypad_sync_2ff #(.WIDTH(4)) u_sync (
    .clk  (Clock),
    .rst_n(Reset),
    .d    (rows),
    .q    (rows_s)
  );

  assign any_low = ~&rows_s;
  assign row_low = ~rows_s[row_q];
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    hit_row = 2'd3;
    if      (!rows_s[0]) hit_row = 2'd0;
    else if (!rows_s[1]) hit_row = 2'd1;
    else if (!rows_s[2]) hit_row = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q >= SETTLE && any_low) begin
          row_d   = hit_row;
          cnt_d   = '0;
          state_d = ST_DEB_PRESS;
        end else if (cnt_q >= SCAN_LAST) begin
          col_d = col_q + 2'd1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DEB_PRESS: begin
        if (!row_low) begin
          // Same column is still settled, so resume sampling it immediately.
          cnt_d   = SETTLE;
          state_d = ST_SCAN;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = ST_EMIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_EMIT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!row_low) begin
          cnt_d   = '0;
          state_d = ST_DEB_REL;
        end
      end
      ST_DEB_REL: begin
        if (row_low) begin
          state_d = ST_HOLD;
        end else if (cnt_q >= DEB_LAST) begin
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_valid = (state_q == ST_EMIT);
  assign hex_digit = key_valid ? key_code(row_q, col_q) : IDLE_CODE;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL provide parameter SCAN_DIV, default 1000: clock cycles each column is driven before advancing.
REQ-002 The block SHALL provide parameter DEBOUNCE, default 20000: clock cycles a key level must be stable to count as pressed or released.
REQ-003 Clock  input  1  single system clock; all flops rise on posedge Clock.
REQ-004 Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
REQ-005 rows  input  4  keypad row lines, active-low, external pull-ups, asynchronous to Clock.
REQ-006 cols  output  4  keypad column drive, active-low, one-hot-zero.
REQ-007 hex_digit  output  4  key code for one cycle per press, else idle code 4'hD.
REQ-008 key_valid  output  1  one-cycle strobe coincident with each emitted code.

Function
REQ-009 The block SHALL pass rows through a 2-flop synchronizer before any use; logic sees synchronized rows only.
REQ-010 Keymap (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *(E),0,#(F),D.
REQ-011 The FSM SHALL have states SCAN, DEB_PRESS, EMIT, HOLD, DEB_REL.
REQ-012 SCAN: drive one column low (col0 first); if all synced rows are high after SCAN_DIV cycles, advance to the next column with wrap 3->0; if any row is low, latch row and column, freeze the column, and go to DEB_PRESS.
REQ-013 DEB_PRESS: the latched row SHALL stay low for DEBOUNCE consecutive cycles, then go to EMIT; any high sample SHALL return to SCAN at the same column.
REQ-014 EMIT: lasts exactly 1 cycle; hex_digit = mapped code, key_valid = 1; then go to HOLD.
REQ-015 HOLD: keep the column frozen; when the latched row reads high, go to DEB_REL.
REQ-016 DEB_REL: the latched row SHALL stay high for DEBOUNCE consecutive cycles, then go to SCAN at the next column; any low sample SHALL go back to HOLD with no new emission.
REQ-017 Outside EMIT, hex_digit SHALL be 4'hD and key_valid SHALL be 0; holding a key SHALL produce exactly one emission.
REQ-018 Key D emits 4'hD with key_valid=1; consumers needing to tell D apart from idle SHALL use key_valid.
REQ-019 With multiple rows low in one column, the lowest-numbered row SHALL win; keys in other columns SHALL be ignored until the block returns to SCAN.
REQ-020 Counters SHALL be sized ceil(log2(max(SCAN_DIV,DEBOUNCE)+1)) bits and SHALL saturate, never wrap.
REQ-021 Latency from the first stable low synced row to EMIT SHALL be DEBOUNCE+1 cycles, plus 2 cycles of synchronizer delay from the pin.

Reset
REQ-022 While Reset=0: state=SCAN, cols=4'b1110, hex_digit=4'hD, key_valid=0, counters=0, synchronizer flops=4'hF.
REQ-023 Reset asserted mid-debounce or mid-HOLD SHALL abort without emission; after release, a still-held key SHALL be debounced anew and emitted once.

Structure
REQ-024 A shared package SHALL hold the state encodings, the 16-entry keymap table, and IDLE_CODE=4'hD, for reuse by keypad consumers.
REQ-025 A sub-module keypad_sync_2ff (4-bit, reset to 1s) SHALL implement the synchronizer; the rest is one module.

Verification (SCAN_DIV=4, DEBOUNCE=8 on the bench)
REQ-026 Reset release, no keys -> cols cycle 1110,1101,1011,0111 every 4 cycles; hex_digit=D, key_valid=0 throughout.
REQ-027 Press r1c0 (key 4) clean for 200 cycles -> exactly one key_valid with hex_digit=4, 11 cycles after the pin goes low (2 synchronizer + 8 debounce + 1); no repeat while held.
REQ-028 Sequence 4, 6, 9 with releases between -> three strobes with codes 4, 6, 9 in order; hex_digit=D between them, so a downstream 3-digit lock unlocks.
REQ-029 r2c2 bounce (low 3, high 2, low 3) then stable low -> no emission during bounce; single emission of 9 after 8 stable cycles; release bounce -> no second emission.
REQ-030 r3c3 pressed -> hex_digit=D with key_valid=1 for one cycle; r0c1 and r2c1 pressed together -> code 2 only.
REQ-031 Reset pulsed during DEB_PRESS of key 5 while held -> no emission before reset; exactly one emission of 5 after re-debounce.
